// File: rtl/latch_bank_loader.sv
// Drives a bank of level-sensitive D latches with a setup / enable-pulse / hold
// sequence, then reads the bank back and flags any mismatch.
module latch_bank_loader #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] D,
  output logic             enable,
  input  logic [WIDTH-1:0] q_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             clr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             last;

  assign last     = (cnt_q == 8'd0);
  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign D        = d_q;
  assign enable   = en_q;
  assign done     = done_q;
  assign err      = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      en_q    <= en_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // enable is registered, so it is decoded from the state being entered:
  // high exactly for the cycles spent in PULSE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    if (clr_err) begin
      err_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          d_d     = in_data;
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      SETUP: begin
        if (last) begin
          state_d = PULSE;
          cnt_d   = PULSE_LD;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      PULSE: begin
        if (last) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
          en_d  = 1'b1;
        end
      end
      HOLD: begin
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          // A new mismatch overrides a simultaneous clr_err.
          if (q_in != d_q) begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
